// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multicycle MIPS sequencer.
// master = controller, slave = datapath.
interface multicycle_control_if;
  logic [5:0] Opcode;
  logic       Zero;
  logic       Mem_Ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       Error;

  modport master (
    input  Opcode, Mem_Ready,
    output PCWrite, PCWriteCond, IorD,
    output MemRead, MemWrite, IRWrite,
    output MemtoReg, RegDst, RegWrite,
    output ALUSrcA, ALUSrcB, ALUOp,
    output PCSource, Error
  );

  modport slave (
    output Opcode, Zero, Mem_Ready,
    input  PCWrite, PCWriteCond, IorD,
    input  MemRead, MemWrite, IRWrite,
    input  MemtoReg, RegDst, RegWrite,
    input  ALUSrcA, ALUSrcB, ALUOp,
    input  PCSource, Error
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore sequencer for the multicycle MIPS datapath with
// memory-ready handshake and wait timeout.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15
) (
  input logic Clock,
  input logic Reset_n,
  multicycle_control_if.master bus
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST =
    CW'(MEM_TIMEOUT - 1);
  localparam logic [CW-1:0] LIMIT =
    CW'(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR,
    MEMRD, MEMWB, MEMWR, RTYPE,
    ALUWB, ADDIEX, ADDIWB, BRANCH,
    JUMP, ERROR
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       error;
    logic       fetch;
  } ctrl_t;

  state_t        state;
  state_t        nxt;
  ctrl_t         ctrl;
  logic [CW-1:0] cnt;
  logic          is_sw;

  logic op_r, op_lw, op_sw;
  logic op_beq, op_j, op_addi;
  logic waiting, timeout;

  assign op_r    = bus.Opcode == 6'b000000;
  assign op_lw   = bus.Opcode == 6'b100011;
  assign op_sw   = bus.Opcode == 6'b101011;
  assign op_beq  = bus.Opcode == 6'b000100;
  assign op_j    = bus.Opcode == 6'b000010;
  assign op_addi = bus.Opcode == 6'b001000;

  assign waiting = state == FETCH ||
                   state == MEMRD ||
                   state == MEMWR;
  assign timeout = !bus.Mem_Ready && cnt == LAST;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:   nxt = FETCH;
      FETCH:
        if (bus.Mem_Ready)  nxt = DECODE;
        else if (timeout)   nxt = ERROR;
      DECODE:
        unique case (1'b1)
          op_r:           nxt = RTYPE;
          op_lw, op_sw:   nxt = MEMADR;
          op_addi:        nxt = ADDIEX;
          op_beq:         nxt = BRANCH;
          op_j:           nxt = JUMP;
          default:        nxt = ERROR;
        endcase
      MEMADR: nxt = is_sw ? MEMWR : MEMRD;
      MEMRD:
        if (bus.Mem_Ready)  nxt = MEMWB;
        else if (timeout)   nxt = ERROR;
      MEMWR:
        if (bus.Mem_Ready)  nxt = FETCH;
        else if (timeout)   nxt = ERROR;
      RTYPE:  nxt = ALUWB;
      ADDIEX: nxt = ADDIWB;
      MEMWB, ALUWB, ADDIWB,
      BRANCH, JUMP:
              nxt = FETCH;
      ERROR:  nxt = ERROR;
      default: nxt = ERROR;
    endcase
  end

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_read = 1'b1;
        c.src_b    = 2'b01;
        c.fetch    = 1'b1;
      end
      DECODE: c.src_b = 2'b11;
      MEMADR: begin
        c.src_a = 1'b1;
        c.src_b = 2'b10;
      end
      MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      RTYPE: begin
        c.src_a  = 1'b1;
        c.alu_op = 2'b10;
      end
      ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      ADDIEX: begin
        c.src_a = 1'b1;
        c.src_b = 2'b10;
      end
      ADDIWB: c.reg_write = 1'b1;
      BRANCH: begin
        c.src_a         = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_src        = 2'b01;
      end
      JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = 2'b10;
      end
      ERROR: c.error = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  // outputs registered from the next state so they line up with it
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state <= IDLE;
      ctrl  <= '0;
      cnt   <= '0;
      is_sw <= 1'b0;
    end else begin
      state <= nxt;
      ctrl  <= decode(nxt);
      if (state == DECODE)
        is_sw <= op_sw;
      if (!waiting || bus.Mem_Ready)
        cnt <= '0;
      else if (cnt != LIMIT)
        cnt <= cnt + 1'b1;
    end
  end

  // fetch completes in the ready cycle itself
  assign bus.IRWrite     = ctrl.fetch & bus.Mem_Ready;
  assign bus.PCWrite     = ctrl.pc_write |
                           (ctrl.fetch & bus.Mem_Ready);
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.IorD        = ctrl.iord;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.ALUSrcA     = ctrl.src_a;
  assign bus.ALUSrcB     = ctrl.src_b;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.PCSource    = ctrl.pc_src;
  assign bus.Error       = ctrl.error;

endmodule
